// File: rtl/dummy_index_collector.sv
// -----------------------------------------------------------------------------
// dummy_index_collector
//
// Rebuilds a WIDTH-bit vector from a stream of bit indices. Each accepted
// index sets one bit of the vector under construction. The vector is emitted
// once BATCH indices have been counted, or earlier when flush_i is seen with
// at least one index counted. An empty vector is never emitted.
//
// Parameters
//   WIDTH  output vector width (>= 2)
//   BATCH  counted indices that close a vector (1 <= BATCH <= WIDTH)
//   IDX_W  index width, derived as $clog2(WIDTH)
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_ni       asynchronous active-low reset
//   idx_i        bit index to set
//   idx_valid_i  idx_i valid
//   idx_ready_o  block accepts idx_i (high while collecting)
//   flush_i      close the current vector early (sampled each cycle)
//   vec_o        collected vector (meaningful only while vec_valid_o is high)
//   vec_valid_o  vec_o valid
//   vec_ready_i  downstream accepts vec_o
//   dup_o        one-cycle pulse: the accepted index was already set
//   err_o        one-cycle pulse: the accepted index was >= WIDTH
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A source never withdraws valid or changes its payload while
// waiting for ready; ready is a pure function of the collector state.
//
// Optional feature
//   DUMMY_COLLECTOR_DUP_CHECK_EN  when defined, duplicate indices pulse dup_o
//   and a simulation-only warning reports the index. When undefined, dup_o
//   is tied low. Counting is identical in both builds.
// -----------------------------------------------------------------------------
module dummy_index_collector #(
    parameter  int WIDTH = 16,
    parameter  int BATCH = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             idx_valid_i,
    output logic             idx_ready_o,
    input  logic             flush_i,
    output logic [WIDTH-1:0] vec_o,
    output logic             vec_valid_o,
    input  logic             vec_ready_i,
    output logic             dup_o,
    output logic             err_o
);

    localparam int CNT_W = $clog2(BATCH + 1);

    typedef enum logic {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_post;
    logic [WIDTH-1:0] idx_onehot;
    logic             accept;
    logic             in_range;
    logic             err_d, err_q;

    assign accept = (state_q == COLLECT) && idx_valid_i;

    // Only reachable as false when WIDTH is not a power of two.
    assign in_range = {1'b0, idx_i} < (IDX_W + 1)'(WIDTH);

    // Out-of-range indices decode to zero so they never touch vec_q.
    assign idx_onehot = in_range ? (WIDTH'(1) << idx_i) : '0;

    // Count after this cycle's accept; duplicates count, out-of-range do not.
    assign cnt_post = cnt_q + CNT_W'(accept && in_range);

    assign err_d = accept && !in_range;

    // Next-state and outputs.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        idx_ready_o = 1'b0;
        vec_valid_o = 1'b0;
        vec_o       = vec_q;
        case (state_q)
            COLLECT: begin
                idx_ready_o = 1'b1;
                if (accept) begin
                    vec_d = vec_q | idx_onehot;
                end
                cnt_d = cnt_post;
                // A flush in the same cycle as an accept includes that index.
                if ((cnt_post == CNT_W'(BATCH)) || (flush_i && (cnt_post != '0))) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                vec_valid_o = 1'b1;
                if (vec_ready_i) begin
                    vec_d   = '0;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= COLLECT;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;

`ifdef DUMMY_COLLECTOR_DUP_CHECK_EN
    logic dup_d, dup_q;

    // Out-of-range indices have an all-zero one-hot, so they never flag.
    assign dup_d = accept && |(vec_q & idx_onehot);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dup_q <= 1'b0;
        end else begin
            dup_q <= dup_d;
        end
    end

    assign dup_o = dup_q;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni && dup_d) begin
            $warning("dummy_index_collector: duplicate index %0d", idx_i);
        end
    end
`endif
`else
    assign dup_o = 1'b0;
`endif

endmodule

// File: tb/tb_dummy_index_collector.sv
// -----------------------------------------------------------------------------
// tb_dummy_index_collector
//
// Two collector instances: a 16-bit one (BATCH=4) for the main paths and a
// 12-bit one (BATCH=4) for out-of-range indices. Stimulus is driven just after
// the rising edge; a monitor per instance samples on the falling edge and pops
// the expected vector whenever a vector handshake is presented.
// -----------------------------------------------------------------------------
module tb_dummy_index_collector;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

`ifdef DUMMY_COLLECTOR_DUP_CHECK_EN
    localparam logic DUP_EN = 1'b1;
`else
    localparam logic DUP_EN = 1'b0;
`endif

    // ---------------- 16-bit instance ----------------
    logic [3:0]  idx_a;
    logic        idx_valid_a;
    logic        idx_ready_a;
    logic        flush_a;
    logic [15:0] vec_a;
    logic        vec_valid_a;
    logic        dup_a;
    logic        err_a;

    // ---------------- 12-bit instance ----------------
    logic [3:0]  idx_b;
    logic        idx_valid_b;
    logic        idx_ready_b;
    logic        flush_b;
    logic [11:0] vec_b;
    logic        vec_valid_b;
    logic        dup_b;
    logic        err_b;

    logic vec_ready;

    dummy_index_collector #(.WIDTH(16), .BATCH(4)) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .idx_i       (idx_a),
        .idx_valid_i (idx_valid_a),
        .idx_ready_o (idx_ready_a),
        .flush_i     (flush_a),
        .vec_o       (vec_a),
        .vec_valid_o (vec_valid_a),
        .vec_ready_i (vec_ready),
        .dup_o       (dup_a),
        .err_o       (err_a)
    );

    dummy_index_collector #(.WIDTH(12), .BATCH(4)) u_dut12 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .idx_i       (idx_b),
        .idx_valid_i (idx_valid_b),
        .idx_ready_o (idx_ready_b),
        .flush_i     (flush_b),
        .vec_o       (vec_b),
        .vec_valid_o (vec_valid_b),
        .vec_ready_i (vec_ready),
        .dup_o       (dup_b),
        .err_o       (err_b)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    logic [11:0] exp12_q[$];

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && vec_valid_a && vec_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL vec16_unexpected: got 0x%0h expected no vector (t=%0t)", vec_a, $time);
            end else begin
                compare("vec16", 32'(vec_a), 32'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && vec_valid_b && vec_ready) begin
            if (exp12_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL vec12_unexpected: got 0x%0h expected no vector (t=%0t)", vec_b, $time);
            end else begin
                compare("vec12", 32'(vec_b), 32'(exp12_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge,
    // where the registered dup/err pulses for this index are visible.
    task automatic send16(input logic [3:0] idx, input logic exp_dup, input logic exp_err,
                          input logic with_flush);
        int n = 0;
        idx_a       = idx;
        idx_valid_a = 1'b1;
        flush_a     = with_flush;
        while (!idx_ready_a && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL idx16_ready_timeout: got ready=0 expected ready=1 within 20 cycles");
        end
        @(posedge clk); #1;
        idx_valid_a = 1'b0;
        flush_a     = 1'b0;
        compare("dup16", 32'(dup_a), 32'(exp_dup));
        compare("err16", 32'(err_a), 32'(exp_err));
    endtask

    task automatic send12(input logic [3:0] idx, input logic exp_err);
        int n = 0;
        idx_b       = idx;
        idx_valid_b = 1'b1;
        while (!idx_ready_b && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL idx12_ready_timeout: got ready=0 expected ready=1 within 20 cycles");
        end
        @(posedge clk); #1;
        idx_valid_b = 1'b0;
        compare("err12", 32'(err_b), 32'(exp_err));
        compare("dup12", 32'(dup_b), 32'd0);
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // Safety net against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n       = 1'b0;
        idx_a       = '0;
        idx_valid_a = 1'b0;
        flush_a     = 1'b0;
        idx_b       = '0;
        idx_valid_b = 1'b0;
        flush_b     = 1'b0;
        vec_ready   = 1'b1;

        // Reset state.
        repeat (2) next_cycle();
        compare("rst_vec_valid", 32'(vec_valid_a), 32'd0);
        compare("rst_idx_ready", 32'(idx_ready_a), 32'd1);
        compare("rst_vec", 32'(vec_a), 32'h0);
        compare("rst_dup", 32'(dup_a), 32'd0);
        compare("rst_err", 32'(err_a), 32'd0);
        compare("rst12_idx_ready", 32'(idx_ready_b), 32'd1);
        rst_n = 1'b1;
        next_cycle();

        // Batch close: 0, 3, 7, 15 back-to-back -> 16'h8089.
        exp_q.push_back(16'h8089);
        send16(4'd0, 1'b0, 1'b0, 1'b0);
        send16(4'd3, 1'b0, 1'b0, 1'b0);
        send16(4'd7, 1'b0, 1'b0, 1'b0);
        compare("batch_not_yet_valid", 32'(vec_valid_a), 32'd0);
        send16(4'd15, 1'b0, 1'b0, 1'b0);
        compare("batch_valid", 32'(vec_valid_a), 32'd1);
        compare("batch_ready_low", 32'(idx_ready_a), 32'd0);
        compare("batch_vec", 32'(vec_a), 32'h8089);
        next_cycle();
        compare("batch_valid_drop", 32'(vec_valid_a), 32'd0);
        compare("batch_ready_back", 32'(idx_ready_a), 32'd1);

        // Flush after a single index -> 16'h0020.
        exp_q.push_back(16'h0020);
        send16(4'd5, 1'b0, 1'b0, 1'b0);
        compare("flush_pending", 32'(vec_valid_a), 32'd0);
        flush_a = 1'b1;
        next_cycle();
        flush_a = 1'b0;
        compare("flush_valid", 32'(vec_valid_a), 32'd1);
        compare("flush_vec", 32'(vec_a), 32'h0020);
        next_cycle();

        // Flush with nothing counted produces no vector.
        flush_a = 1'b1;
        next_cycle();
        flush_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            compare("empty_flush_no_valid", 32'(vec_valid_a), 32'd0);
            next_cycle();
        end

        // Flush in the same cycle as an accept includes that index.
        exp_q.push_back(16'h0200);
        send16(4'd9, 1'b0, 1'b0, 1'b1);
        compare("flush_accept_valid", 32'(vec_valid_a), 32'd1);
        compare("flush_accept_vec", 32'(vec_a), 32'h0200);
        next_cycle();

        // Backpressure: hold vec_ready low for 5 cycles with an index waiting.
        vec_ready = 1'b0;
        exp_q.push_back(16'h0116);
        send16(4'd1, 1'b0, 1'b0, 1'b0);
        send16(4'd2, 1'b0, 1'b0, 1'b0);
        send16(4'd4, 1'b0, 1'b0, 1'b0);
        send16(4'd8, 1'b0, 1'b0, 1'b0);
        idx_a       = 4'd3;
        idx_valid_a = 1'b1;
        flush_a     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            compare("bp_valid", 32'(vec_valid_a), 32'd1);
            compare("bp_ready_low", 32'(idx_ready_a), 32'd0);
            compare("bp_vec_stable", 32'(vec_a), 32'h0116);
            next_cycle();
        end
        idx_valid_a = 1'b0;
        flush_a     = 1'b0;
        vec_ready   = 1'b1;
        next_cycle();
        compare("bp_release_valid", 32'(vec_valid_a), 32'd0);
        compare("bp_release_ready", 32'(idx_ready_a), 32'd1);
        compare("bp_release_cleared", 32'(vec_a), 32'h0);

        // Duplicate: 2, 2, 4, 6 -> 16'h0054; dup pulses only in the checked build.
        exp_q.push_back(16'h0054);
        send16(4'd2, 1'b0, 1'b0, 1'b0);
        send16(4'd2, DUP_EN, 1'b0, 1'b0);
        send16(4'd4, 1'b0, 1'b0, 1'b0);
        send16(4'd6, 1'b0, 1'b0, 1'b0);
        compare("dup_close_valid", 32'(vec_valid_a), 32'd1);
        compare("dup_vec", 32'(vec_a), 32'h0054);
        next_cycle();

        // Out of range on the 12-bit instance: 13 flags, then 1,2,3,4 -> 12'h01E.
        exp12_q.push_back(12'h01E);
        send12(4'd13, 1'b1);
        compare("oor_no_valid", 32'(vec_valid_b), 32'd0);
        send12(4'd1, 1'b0);
        send12(4'd2, 1'b0);
        send12(4'd3, 1'b0);
        compare("oor_not_closed_at_3", 32'(vec_valid_b), 32'd0);
        send12(4'd4, 1'b0);
        compare("oor_closed_valid", 32'(vec_valid_b), 32'd1);
        compare("oor_vec", 32'(vec_b), 32'h01E);
        next_cycle();

        // Reset mid-operation discards a partial vector.
        send16(4'd1, 1'b0, 1'b0, 1'b0);
        send16(4'd2, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        compare("midrst_vec", 32'(vec_a), 32'h0);
        compare("midrst_valid", 32'(vec_valid_a), 32'd0);
        compare("midrst_ready", 32'(idx_ready_a), 32'd1);
        compare("midrst_dup", 32'(dup_a), 32'd0);
        compare("midrst_err", 32'(err_a), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        exp_q.push_back(16'h0F00);
        send16(4'd8, 1'b0, 1'b0, 1'b0);
        send16(4'd9, 1'b0, 1'b0, 1'b0);
        send16(4'd10, 1'b0, 1'b0, 1'b0);
        compare("midrst_count_restart", 32'(vec_valid_a), 32'd0);
        send16(4'd11, 1'b0, 1'b0, 1'b0);
        compare("midrst_close_valid", 32'(vec_valid_a), 32'd1);
        compare("midrst_own_bits", 32'(vec_a), 32'h0F00);
        next_cycle();

        // Every expected vector must have been presented.
        repeat (3) next_cycle();
        compare("exp16_drained", 32'(exp_q.size()), 32'd0);
        compare("exp12_drained", 32'(exp12_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dummy_index_collector.md
# dummy_index_collector

Inverse companion of the leading-zero-count path in the dummy VIP. The count path reduces a bit vector to an index. This block takes a stream of bit indices over a valid/ready handshake and rebuilds a WIDTH-bit vector from them. It emits the vector once BATCH indices have been accepted, or earlier on a flush. The block sits in the dummy VIP next to the count-based submodule, so the two paths can be chained in loopback for the integration exercise.

## Interface
- WIDTH, 16: output vector width; any value >= 2.
- BATCH, 4: number of counted indices that closes a vector; 1 <= BATCH <= WIDTH.
- IDX_W, $clog2(WIDTH): index width; derived, never overridden.
- clk_i  input  1  clock; all state on rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- idx_i  input  IDX_W  bit index to set.
- idx_valid_i  input  1  idx_i valid.
- idx_ready_o  output  1  block accepts idx_i.
- flush_i  input  1  close the current vector early; single-cycle level sample.
- vec_o  output  WIDTH  collected vector.
- vec_valid_o  output  1  vec_o valid.
- vec_ready_i  input  1  downstream accepts vec_o.
- dup_o  output  1  one-cycle pulse: accepted index was already set.
- err_o  output  1  one-cycle pulse: accepted index >= WIDTH.

## Operation
- Two states: COLLECT (reset state) and OUTPUT.
- Internal registers:
  - vec_q: WIDTH bits.
  - cnt_q: $clog2(BATCH+1) bits.
- **COLLECT**
  - idx_ready_o = 1 and vec_valid_o = 0.
  - An index is accepted when idx_valid_i && idx_ready_o.
  - Accepted idx < WIDTH: set vec_q[idx] and increment cnt_q.
  - Accepted idx >= WIDTH (only possible when WIDTH is not a power of two): vec_q and cnt_q unchanged; err_o pulses.
- **Duplicates**
  - A duplicate index (bit already 1) still increments cnt_q.
  - vec_q is unchanged by a duplicate; dup_o pulses.
- **COLLECT -> OUTPUT transitions**
  - When the post-accept count equals BATCH.
  - When flush_i = 1 and the post-accept count > 0.
  - Flush in the same cycle as an accept: the index is included, then the block transitions.
  - Flush with a count of 0 and no accept is ignored. No empty vector is ever emitted.
- **OUTPUT**
  - idx_ready_o = 0 and vec_valid_o = 1.
  - vec_o = vec_q, held stable until the handshake.
  - flush_i is ignored.
  - On vec_ready_i: clear vec_q and cnt_q, return to COLLECT.
- vec_o is driven from vec_q in every state. Its value is only meaningful when vec_valid_o = 1.

## Timing
- Reset values:
  - State = COLLECT.
  - vec_o = 0, vec_valid_o = 0.
  - idx_ready_o = 1 (combinational from state).
  - dup_o = 0, err_o = 0.
- vec_valid_o rises in the cycle after the closing accept or flush (1-cycle latency).
- The vector is consumed in the first cycle where vec_valid_o && vec_ready_i. idx_ready_o returns to 1 in the next cycle.
- Throughput: a minimum of BATCH+1 cycles per vector with vec_ready_i held high.
- dup_o and err_o are registered and pulse in the cycle after the offending accept.
- If a handshake is pending, vec_valid_o and vec_o must not change until it completes.
- Reset asserted mid-operation:
  - All state clears immediately (asynchronous).
  - Any partial vector is discarded.
  - The first cycle after deassertion is COLLECT with cnt_q = 0.

## Configuration
- Macro: DUMMY_COLLECTOR_DUP_CHECK_EN.
- Defined:
  - dup_o is driven as described above.
  - A simulation-only $warning reports the duplicate index value.
- Undefined:
  - dup_o is tied to 0 and no duplicate-detection logic is built.
  - A duplicate still increments cnt_q, so counting behaviour is identical.

## Test plan
- **Batch close.** WIDTH=16, BATCH=4, vec_ready_i=1; send indices 0, 3, 7, 15 back-to-back. Expect: vec_valid_o for one cycle, one cycle after the 4th accept, with vec_o = 16'h8089; idx_ready_o low for exactly that cycle.
- **Flush.** Send index 5, then pulse flush_i alone. Expect: vec_o = 16'h0020, valid the next cycle. A flush with no pending index produces no output.
- **Backpressure.** Close a batch with vec_ready_i=0 for 5 cycles. Expect: vec_o stable and idx_ready_o=0 throughout; release accepts the vector and idx_ready_o=1 the next cycle.
- **Duplicate.** Macro defined; send 2, 2, 4, 6. Expect: dup_o pulse after the 2nd accept and vec_o = 16'h0054 after the 4th. Macro undefined: same vec_o, dup_o never asserts.
- **Out of range.** WIDTH=12; send index 13, then 1, 2, 3, 4. Expect: err_o pulse after the first accept; vector closes only after index 4, with vec_o = 12'h01E.
- **Reset mid-operation.** Accept 2 indices, then assert rst_ni low for 1 cycle. Expect: all outputs at reset values; the next batch of 4 yields only its own bits.
